div_restore: RTL and testbench

Sequential restoring divider that undoes the multiply-accumulate datapath. It accepts a packed result `data_in = A*B + C`, where `C < B`, together with the multiplier `B`. It recovers `A` as the quotient and `C` as the remainder, one quotient bit per clock. It sits downstream of the MAC stage and checks or unpacks its output through a start/busy/done handshake.

---
 rtl/div_restore.sv | 119 +++++++++++
 tb/tb_div_restore.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_restore.sv
// Sequential restoring divider: unpacks data_in = A*B + C into quot = A and rem = C,
// producing one quotient bit per clock behind a start/busy/done handshake.
module div_restore #(
  parameter int size    = 8,
  parameter int outsize = 16
) (
  input  logic               clc,
  input  logic               rst,
  input  logic               start,
  input  logic [outsize-1:0] data_in,
  input  logic [size-1:0]    B,
  output logic [outsize-1:0] quot,
  output logic [size-1:0]    rem,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               ovf
);

  localparam int CW = (outsize > 1) ? $clog2(outsize) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [outsize-1:0] dvd_q, dvd_d;
  logic [size:0]      wrem_q, wrem_d;
  logic [size-1:0]    dvs_q;
  logic [CW-1:0]      cnt_q;
  logic               dz_q;
  logic [outsize-1:0] quot_q;
  logic [size-1:0]    rem_q;
  logic               busy_q, done_q, div_zero_q, ovf_q;

  logic [size+1:0]    shifted;
  logic [size+1:0]    trial;
  logic               fits;

  // Dividend and quotient share one shift register: dividend bits leave at the
  // MSB while quotient bits enter at the LSB.
  always_comb begin
    shifted = {1'b0, wrem_q, dvd_q[outsize-1]};
    trial   = shifted - {2'b00, dvs_q};
    fits    = ~trial[size+1];
    wrem_d  = fits ? trial[size:0] : shifted[size:0];
    dvd_d   = {dvd_q[outsize-2:0], fits};
  end

  always_ff @(posedge clc or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      wrem_q     <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      dz_q       <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (B != '0) begin
              dvd_q   <= data_in;
              dvs_q   <= B;
              wrem_q  <= '0;
              cnt_q   <= CW'(outsize - 1);
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              dz_q    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          dvd_q  <= dvd_d;
          wrem_q <= wrem_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            quot_q     <= dvd_d;
            rem_q      <= wrem_d[size-1:0];
            div_zero_q <= 1'b0;
            ovf_q      <= |dvd_d[outsize-1:size];
          end
        end
        DONE: begin
          // Divide-by-zero results are published here, one edge after acceptance.
          state_q <= IDLE;
          if (dz_q) begin
            done_q     <= 1'b1;
            quot_q     <= '1;
            rem_q      <= '0;
            div_zero_q <= 1'b1;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_div_restore.sv
// Directed and randomized bench for div_restore (size 8, outsize 16).
module tb_div_restore;

  logic        clc = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [7:0]  B;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        busy, done, div_zero, ovf;

  int total_cnt = 0;
  int pass_cnt  = 0;

  div_restore #(.size(8), .outsize(16)) dut (
    .clc(clc), .rst(rst), .start(start), .data_in(data_in), .B(B),
    .quot(quot), .rem(rem), .busy(busy), .done(done),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clc = ~clc;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic start_op(input logic [15:0] din, input logic [7:0] b, output int bcnt);
    @(negedge clc);
    start   = 1'b1;
    data_in = din;
    B       = b;
    @(posedge clc);
    #1;
    start = 1'b0;
    bcnt  = busy ? 1 : 0;
  endtask

  task automatic finish_op(input string name, input logic [15:0] eq, input logic [7:0] er,
                           input logic eovf, input logic edz, input int elat, input int ebsy,
                           input int bcnt_in);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = bcnt_in;
    while (lat < 40) begin
      @(posedge clc);
      #1;
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    chk({name, " done_seen"}, 32'(done), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(elat));
    chk({name, " busy_cycles"}, 32'(bcnt), 32'(ebsy));
    chk({name, " quot"}, 32'(quot), 32'(eq));
    chk({name, " rem"}, 32'(rem), 32'(er));
    chk({name, " ovf"}, 32'(ovf), 32'(eovf));
    chk({name, " div_zero"}, 32'(div_zero), 32'(edz));
    @(posedge clc);
    #1;
    chk({name, " done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int bc;
    int a, bb, c;
    logic seen_done;

    vecs[0] = '{16'd180,  8'd7,   16'd25,     8'd5,   1'b0, 1'b0, 16, 16};
    vecs[1] = '{16'hFFFF, 8'hFF,  16'h0101,   8'd0,   1'b1, 1'b0, 16, 16};
    vecs[2] = '{16'd0,    8'd3,   16'd0,      8'd0,   1'b0, 1'b0, 16, 16};
    vecs[3] = '{16'h1234, 8'd1,   16'h1234,   8'd0,   1'b1, 1'b0, 16, 16};
    vecs[4] = '{16'd100,  8'd0,   16'hFFFF,   8'd0,   1'b0, 1'b1, 1,  0};
    vecs[5] = '{16'd1000, 8'd255, 16'd3,      8'd235, 1'b0, 1'b0, 16, 16};
    vecs[6] = '{16'd255,  8'd16,  16'd15,     8'd15,  1'b0, 1'b0, 16, 16};
    vecs[7] = '{16'hFFFF, 8'd1,   16'hFFFF,   8'd0,   1'b1, 1'b0, 16, 16};

    // Reset with arbitrary inputs applied
    rst     = 1'b0;
    start   = 1'b1;
    data_in = 16'($urandom);
    B       = 8'($urandom);
    repeat (3) @(posedge clc);
    #1;
    chk("rst quot", 32'(quot), 32'd0);
    chk("rst rem", 32'(rem), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst div_zero", 32'(div_zero), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    @(negedge clc);
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clc);
    #1;
    chk("post_rst busy", 32'(busy), 32'd0);
    chk("post_rst done", 32'(done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].din, vecs[i].b, bc);
      finish_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].dz,
                vecs[i].lat, vecs[i].bsy, bc);
    end

    // Start pulses during CALC (edge 3) and DONE (edge 17) must be ignored
    start_op(16'd180, 8'd7, bc);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clc);
      #1;
      if (k == 3) chk("sb busy_at_3", 32'(busy), 32'd1);
      if (k == 16) begin
        chk("sb done_at_16", 32'(done), 32'd1);
        chk("sb quot", 32'(quot), 32'd25);
        chk("sb rem", 32'(rem), 32'd5);
      end
      if (k == 17) begin
        chk("sb busy_after_17", 32'(busy), 32'd0);
        chk("sb done_after_17", 32'(done), 32'd0);
      end
      start   = (k == 2) || (k == 16);
      data_in = 16'd50;
      B       = 8'd5;
    end
    start_op(16'd50, 8'd5, bc);
    finish_op("sb next", 16'd10, 8'd0, 1'b0, 1'b0, 16, 16, bc);

    // Asynchronous reset during CALC aborts without a done pulse
    start_op(16'd180, 8'd7, bc);
    repeat (5) @(posedge clc);
    #2;
    rst = 1'b0;
    #1;
    chk("abort quot", 32'(quot), 32'd0);
    chk("abort rem", 32'(rem), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort div_zero", 32'(div_zero), 32'd0);
    chk("abort ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clc);
    @(negedge clc);
    rst = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clc);
      #1;
      seen_done |= done | busy;
    end
    chk("abort no_activity", 32'(seen_done), 32'd0);
    start_op(16'd180, 8'd7, bc);
    finish_op("after_abort", 16'd25, 8'd5, 1'b0, 1'b0, 16, 16, bc);

    // Randomized A*B+C with C < B
    for (int n = 0; n < 1000; n++) begin
      bb = int'($urandom_range(1, 255));
      a  = int'($urandom_range(0, (65536 - bb) / bb));
      c  = int'($urandom_range(0, bb - 1));
      start_op(16'(a * bb + c), 8'(bb), bc);
      finish_op($sformatf("rnd%0d", n), 16'(a), 8'(c), 1'(a > 255), 1'b0, 16, 16, bc);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
